// File: rtl/mult_host_sequencer_if.sv
// mult_host_sequencer_if: operand stream, result stream and core start/done bundle.
interface mult_host_sequencer_if #(
  parameter int A_WIDTH = 16,
  parameter int R_WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [A_WIDTH-1:0] in_a;
  logic [A_WIDTH-1:0] in_b;
  logic [A_WIDTH-1:0] core_a;
  logic [A_WIDTH-1:0] core_b;
  logic               core_start;
  logic               core_done;
  logic [R_WIDTH-1:0] core_result;
  logic               out_valid;
  logic               out_ready;
  logic [R_WIDTH-1:0] out_result;
  modport master (
    input  in_valid, in_a, in_b, core_done, core_result, out_ready,
    output in_ready, core_a, core_b, core_start, out_valid, out_result
  );
  modport slave (
    output in_valid, in_a, in_b, core_done, core_result, out_ready,
    input  in_ready, core_a, core_b, core_start, out_valid, out_result
  );
endinterface

// File: rtl/mult_host_sequencer.sv
// mult_host_sequencer: host-side start/done initiator for the shift multiplier core.
// Optional WAIT watchdog enabled by defining MULT_SEQ_TIMEOUT_EN.
module mult_host_sequencer #(
  parameter int A_WIDTH = 16,
  parameter int R_WIDTH = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_host_sequencer_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state, state_n;
  logic   timed_out;
  if (R_WIDTH < 2 * A_WIDTH || TIMEOUT < 1) begin : g_bad_cfg
    $error("mult_host_sequencer: R_WIDTH must be >= 2*A_WIDTH and TIMEOUT >= 1");
  end
`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
  assign timed_out = state == WAIT && !bus.core_done && wait_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt    <= state == WAIT ? wait_cnt + 1'b1 : '0;
      timeout_err <= timeout_err | timed_out;
    end
`else
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.in_valid ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = bus.core_done || timed_out ? HOLD : WAIT;
      HOLD:    state_n = bus.out_ready ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  assign bus.in_ready   = state == IDLE;
  assign bus.core_start = state == ISSUE;
  assign bus.out_valid  = state == HOLD;
  assign busy           = state != IDLE;
  // core_done only counts in WAIT; a timeout delivers a zero product instead
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state          <= IDLE;
      bus.core_a     <= '0;
      bus.core_b     <= '0;
      bus.out_result <= '0;
      op_count       <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        bus.core_a <= bus.in_a;
        bus.core_b <= bus.in_b;
      end
      if (state == WAIT && bus.core_done) begin
        bus.out_result <= bus.core_result;
        op_count       <= op_count + 1'b1;
      end else if (timed_out) begin
        bus.out_result <= '0;
      end
    end
endmodule

// File: tb/tb_mult_host_sequencer.sv
// tb_mult_host_sequencer: directed table-driven bench with a hand-modelled core.
module tb_mult_host_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic [7:0] op_count;
  logic       timeout_err;
  int         n_chk = 0;
  int         n_fail = 0;
  int         starts = 0;
  logic [7:0] exp_cnt = '0;
  mult_host_sequencer_if #(.A_WIDTH(16), .R_WIDTH(32)) bus ();
  mult_host_sequencer #(.A_WIDTH(16), .R_WIDTH(32), .TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .op_count(op_count), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.core_start) starts++;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [31:0] prod;
    int          hold;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    chk("accept_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("issue_start", bus.core_start, 1);
    chk("issue_core_a", bus.core_a, a);
    chk("issue_core_b", bus.core_b, b);
  endtask
  task automatic complete(input int lat, input logic [31:0] prod, input int s0);
    repeat (lat) @(negedge clk);
    chk("wait_no_valid", bus.out_valid, 0);
    bus.core_done   = 1'b1;
    bus.core_result = prod;
    @(negedge clk);
    bus.core_done   = 1'b0;
    bus.core_result = 32'hDEAD_BEEF;
    exp_cnt++;
    chk("hold_valid", bus.out_valid, 1);
    chk("hold_result", bus.out_result, prod);
    chk("op_count", op_count, exp_cnt);
    chk("one_start_pulse", starts, s0 + 1);
  endtask
  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_ready", bus.in_ready, 1);
  endtask
  initial begin
    int s0;
    vecs[0] = '{16'd3,      16'd5,      12, 32'd15,         0};
    vecs[1] = '{16'd0,      16'd1234,   2,  32'd0,          1};
    vecs[2] = '{16'hFFFF,   16'hFFFF,   3,  32'hFFFE_0001,  2};
    vecs[3] = '{16'd100,    16'd200,    1,  32'd20000,      0};
    vecs[4] = '{16'h8000,   16'd2,      5,  32'h0001_0000,  3};
    bus.in_valid = 1'b1; bus.in_a = 16'd11; bus.in_b = 16'd22;
    bus.core_done = 1'b0; bus.core_result = '0; bus.out_ready = 1'b0;
    // T1: reset held with in_valid high
    repeat (3) @(negedge clk);
    chk("rst_core_a", bus.core_a, 0);
    chk("rst_core_b", bus.core_b, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.in_ready, 1);
    chk("post_rst_busy", busy, 0);
    // T2 and table-driven ops
    foreach (vecs[i]) begin
      s0 = starts;
      issue(vecs[i].a, vecs[i].b);
      chk("issue_busy", busy, 1);
      complete(vecs[i].lat, vecs[i].prod, s0);
      repeat (vecs[i].hold) begin
        @(negedge clk);
        chk("hold_stable_valid", bus.out_valid, 1);
        chk("hold_stable_result", bus.out_result, vecs[i].prod);
      end
      release_out();
    end
    // T3: backpressure with the next operand already waiting
    s0 = starts;
    issue(16'd7, 16'd9);
    complete(4, 32'd63, s0);
    bus.in_valid = 1'b1; bus.in_a = 16'd1; bus.in_b = 16'd2;
    repeat (10) begin
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_result", bus.out_result, 63);
      chk("bp_valid", bus.out_valid, 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_idle_ready", bus.in_ready, 1);
    chk("bp_core_a_held", bus.core_a, 7);
    s0 = starts;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_next_start", bus.core_start, 1);
    chk("bp_next_core_a", bus.core_a, 1);
    chk("bp_next_core_b", bus.core_b, 2);
    complete(3, 32'd2, s0);
    release_out();
    // T4: stray core_done in IDLE, then in ISSUE
    bus.core_done = 1'b1; bus.core_result = 32'd777;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("stray_idle_valid", bus.out_valid, 0);
    chk("stray_idle_busy", busy, 0);
    chk("stray_idle_count", op_count, exp_cnt);
    s0 = starts;
    issue(16'd4, 16'd4);
    bus.core_done = 1'b1; bus.core_result = 32'd999;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("stray_issue_valid", bus.out_valid, 0);
    chk("stray_issue_count", op_count, exp_cnt);
    chk("stray_issue_busy", busy, 1);
    complete(2, 32'd16, s0);
    chk("stray_result", bus.out_result, 16);
    release_out();
    // T5: run to 256 completed operations
    for (int i = int'(exp_cnt); i < 256; i++) begin
      s0 = starts;
      issue(16'(i), 16'd1);
      complete(1, 32'(i), s0);
      release_out();
    end
    chk("wrap_count", op_count, 0);
`ifdef MULT_SEQ_TIMEOUT_EN
    // T6: no core_done, watchdog fires after 64 WAIT cycles
    issue(16'd9, 16'd9);
    repeat (64) @(negedge clk);
    chk("to_not_yet_err", timeout_err, 0);
    chk("to_not_yet_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("to_err", timeout_err, 1);
    chk("to_valid", bus.out_valid, 1);
    chk("to_result", bus.out_result, 0);
    chk("to_count", op_count, exp_cnt);
    release_out();
    chk("to_sticky", timeout_err, 1);
`endif
    // T5 second part: reset asserted while waiting for the core
    issue(16'd5, 16'd6);
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_core_a", bus.core_a, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
    @(negedge clk);
    chk("post_mid_rst_count", op_count, exp_cnt);
    chk("post_mid_rst_ready", bus.in_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
